// File: rtl/fpu_req_arb.sv
// rtl/fpu_req_arb.sv - round-robin arbiter sequencing NREQ requesters onto one shared FPU
module fpu_req_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [4*NREQ-1:0]  req_cmd,
  input  logic [64*NREQ-1:0] req_din1,
  input  logic [64*NREQ-1:0] req_din2,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [63:0]        rsp_result,
  output logic               rsp_err,
  output logic               busy,
  output logic [3:0]         fpu_cmd,
  output logic [63:0]        fpu_din1,
  output logic [63:0]        fpu_din2,
  output logic               fpu_dval,
  input  logic [63:0]        fpu_result,
  input  logic               fpu_rdy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // counter only has to reach TIMEOUT-1
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last;
  logic [3:0]      r_cmd;
  logic [63:0]     r_din1;
  logic [63:0]     r_din2;
  logic [63:0]     r_result;
  logic            r_err;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_ack;

  logic [3:0]      w_cmd  [NREQ];
  logic [63:0]     w_din1 [NREQ];
  logic [63:0]     w_din2 [NREQ];
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_cand;
  logic [3:0]      w_cmd_sel;
  logic            w_legal;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_cmd[g]  = req_cmd[4*g +: 4];
    assign w_din1[g] = req_din1[64*g +: 64];
    assign w_din2[g] = req_din2[64*g +: 64];
  end

  // Round-robin search: first valid requester strictly after the last owner, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(r_last) + k) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_cmd_sel = w_cmd[w_win];
  assign w_legal   = (w_cmd_sel == 4'b0101) || (w_cmd_sel == 4'b0110) || (w_cmd_sel == 4'b0111);

  // Outputs decode from registered state; the FPU command is forced idle outside ISSUE/WAIT
  assign busy       = (r_state != S_IDLE);
  assign fpu_dval   = (r_state == S_ISSUE);
  assign fpu_cmd    = ((r_state == S_ISSUE) || (r_state == S_WAIT)) ? r_cmd : 4'b0000;
  assign fpu_din1   = r_din1;
  assign fpu_din2   = r_din2;
  assign req_ack    = r_ack;
  assign rsp_valid  = (r_state == S_RESP) ? (NREQ'(1) << r_owner) : '0;
  assign rsp_result = (r_state == S_RESP) ? r_result : 64'd0;
  assign rsp_err    = (r_state == S_RESP) & r_err;

  // Sequencer: grant, issue, wait for completion or timeout, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_last   <= IW'(NREQ - 1);
      r_cmd    <= '0;
      r_din1   <= '0;
      r_din2   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_ack    <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_win;
            r_cmd   <= w_cmd_sel;
            r_din1  <= w_din1[w_win];
            r_din2  <= w_din2[w_win];
            r_ack   <= NREQ'(1) << w_win;
            if (w_legal) begin
              r_state <= S_ISSUE;
            end else begin
              r_result <= 64'd0;
              r_err    <= 1'b1;
              r_state  <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
          if (fpu_rdy) begin
            r_result <= fpu_result;
            r_err    <= 1'b0;
            r_state  <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // a completion in the expiry cycle still counts as success
          if (fpu_rdy) begin
            r_result <= fpu_result;
            r_err    <= 1'b0;
            r_state  <= S_RESP;
          end else if (r_cnt == C_LAST) begin
            r_result <= 64'd0;
            r_err    <= 1'b1;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_req_arb.sv
// tb/tb_fpu_req_arb.sv - scoreboard bench for fpu_req_arb with a timing-level reference model
module tb_fpu_req_arb;

  localparam int NREQ = 4;
  localparam int TMO  = 8;
  localparam logic [63:0] IDLE_RES = 64'hFFFF_0000_FFFF_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [4*NREQ-1:0]  req_cmd = '0;
  logic [64*NREQ-1:0] req_din1 = '0;
  logic [64*NREQ-1:0] req_din2 = '0;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    rsp_valid;
  logic [63:0]        rsp_result;
  logic               rsp_err;
  logic               busy;
  logic [3:0]         fpu_cmd;
  logic [63:0]        fpu_din1;
  logic [63:0]        fpu_din2;
  logic               fpu_dval;
  logic [63:0]        fpu_result = IDLE_RES;
  logic               model_rdy = 1'b0;
  logic               spur_rdy = 1'b0;
  wire                fpu_rdy_w = model_rdy | spur_rdy;

  always #5 clk = ~clk;

  fpu_req_arb #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_din1(req_din1), .req_din2(req_din2),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .fpu_cmd(fpu_cmd), .fpu_din1(fpu_din1), .fpu_din2(fpu_din2),
    .fpu_dval(fpu_dval), .fpu_result(fpu_result), .fpu_rdy(fpu_rdy_w)
  );

  typedef struct { int who; logic [3:0] cmd; logic [63:0] a; logic [63:0] b; int lat; } job_t;
  typedef struct { int who; logic [63:0] res; logic err; int cyc; } rsp_t;
  typedef struct { int who; int cyc; } ack_t;
  typedef struct { logic [3:0] cmd; logic [63:0] a; logic [63:0] b; int lat; int cyc; } op_t;

  job_t jobq[$];
  rsp_t rspq[$];
  ack_t ackq[$];
  op_t  opq[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int m_last = NREQ - 1;
  int next_sample = 0;
  int ack_who = -1;
  int ack_at = 0;
  int last_sample = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic bit legal(logic [3:0] c);
    return (c == 4'b0101) || (c == 4'b0110) || (c == 4'b0111);
  endfunction

  function automatic logic [63:0] fp_op(logic [3:0] c, logic [63:0] a, logic [63:0] b);
    real x, y;
    x = $bitstoreal(a);
    y = $bitstoreal(b);
    case (c)
      4'b0101: return $realtobits(x + y);
      4'b0110: return $realtobits(x * y);
      4'b0111: return $realtobits(x / y);
      default: return 64'd0;
    endcase
  endfunction

  function automatic int head_idx(int who);
    for (int k = 0; k < jobq.size(); k++)
      if (jobq[k].who == who) return k;
    return -1;
  endfunction

  function automatic logic [63:0] rnd_op();
    return $realtobits(real'($urandom_range(1, 1000)));
  endfunction

  task automatic add_job(int who, logic [3:0] c, logic [63:0] a, logic [63:0] b, int lat);
    job_t j;
    j.who = who; j.cmd = c; j.a = a; j.b = b; j.lat = lat;
    jobq.push_back(j);
  endtask

  // Present each requester's oldest job; at every cycle the arbiter is idle, predict the grant and response
  task automatic drive_step();
    logic [NREQ-1:0]    v;
    logic [4*NREQ-1:0]  c;
    logic [64*NREQ-1:0] a;
    logic [64*NREQ-1:0] b;
    int   h, w, cand;
    job_t j;
    rsp_t r;
    ack_t k;
    op_t  o;
    if (ack_who >= 0 && cyc >= ack_at) begin
      h = head_idx(ack_who);
      if (h >= 0) jobq.delete(h);
      ack_who = -1;
    end
    v = '0; c = '0; a = '0; b = '0;
    for (int i = 0; i < NREQ; i++) begin
      h = head_idx(i);
      if (h >= 0) begin
        v = v | (NREQ'(1) << i);
        c = c | ((4*NREQ)'(jobq[h].cmd) << (4*i));
        a = a | ((64*NREQ)'(jobq[h].a) << (64*i));
        b = b | ((64*NREQ)'(jobq[h].b) << (64*i));
      end
    end
    req_valid = v; req_cmd = c; req_din1 = a; req_din2 = b;
    if (ack_who < 0 && cyc >= next_sample && v != '0) begin
      w = -1;
      for (int n = 1; n <= NREQ; n++) begin
        cand = (m_last + n) % NREQ;
        if (w < 0 && head_idx(cand) >= 0) w = cand;
      end
      j = jobq[head_idx(w)];
      k.who = w; k.cyc = cyc + 1;
      ackq.push_back(k);
      r.who = w;
      if (!legal(j.cmd)) begin
        r.res = 64'd0; r.err = 1'b1; r.cyc = cyc + 1;
      end else begin
        o.cmd = j.cmd; o.a = j.a; o.b = j.b; o.lat = j.lat; o.cyc = cyc + 1;
        opq.push_back(o);
        if (j.lat == 0) begin
          r.res = 64'd0; r.err = 1'b1; r.cyc = cyc + TMO + 2;
        end else begin
          r.res = fp_op(j.cmd, j.a, j.b); r.err = 1'b0; r.cyc = cyc + j.lat + 2;
        end
      end
      rspq.push_back(r);
      m_last = w;
      next_sample = r.cyc + 1;
      ack_who = w;
      ack_at = cyc + 1;
      last_sample = cyc;
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive_step();
  endtask

  task automatic drain(int maxc);
    int n;
    n = 0;
    while ((jobq.size() > 0 || rspq.size() > 0 || ackq.size() > 0) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) flag("drain_timeout");
    repeat (2) step();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_req_ack"}, req_ack, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fpu_cmd"}, fpu_cmd, 0);
    chk({tag, "_fpu_din1"}, fpu_din1, 0);
    chk({tag, "_fpu_din2"}, fpu_din2, 0);
    chk({tag, "_fpu_dval"}, fpu_dval, 0);
  endtask

  // Monitor: pop expected acks/responses whenever the DUT presents them
  initial begin
    ack_t ea;
    rsp_t er;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_ack != '0) begin
          if (ackq.size() == 0) flag("unexpected_req_ack");
          else begin
            ea = ackq.pop_front();
            chk("req_ack", req_ack, NREQ'(1) << ea.who);
            chk("ack_cycle", cyc, ea.cyc);
          end
        end
        if (rsp_valid != '0) begin
          if (rspq.size() == 0) flag("unexpected_rsp_valid");
          else begin
            er = rspq.pop_front();
            chk("rsp_valid", rsp_valid, NREQ'(1) << er.who);
            chk("rsp_result", rsp_result, er.res);
            chk("rsp_err", rsp_err, er.err);
            chk("rsp_cycle", cyc, er.cyc);
            chk("fpu_cmd_resp", fpu_cmd, 0);
          end
        end
        if (!busy) chk("fpu_cmd_idle", fpu_cmd, 0);
      end
    end
  end

  // FPU model: answers each start pulse after the latency chosen for that op (0 = never)
  initial begin
    op_t o;
    forever begin
      @(negedge clk);
      if (rst_n && fpu_dval) begin
        if (opq.size() == 0) flag("unexpected_fpu_dval");
        else begin
          o = opq.pop_front();
          chk("dval_cycle", cyc, o.cyc);
          chk("fpu_cmd", fpu_cmd, o.cmd);
          chk("fpu_din1", fpu_din1, o.a);
          chk("fpu_din2", fpu_din2, o.b);
          if (o.lat > 0) begin
            repeat (o.lat) @(negedge clk);
            chk("fpu_cmd_hold", fpu_cmd, o.cmd);
            chk("fpu_dval_pulse", fpu_dval, 0);
            model_rdy = 1'b1;
            fpu_result = fp_op(o.cmd, o.a, o.b);
            @(negedge clk);
            model_rdy = 1'b0;
            fpu_result = IDLE_RES;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    next_sample = cyc;
    drive_step();

    // single add, 1.0 + 2.0, FPU latency 3
    add_job(0, 4'b0101, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 3);
    drain(100);

    // illegal command: immediate error response, no FPU start
    add_job(2, 4'b0001, rnd_op(), rnd_op(), 1);
    drain(100);

    // hung FPU times out, next request still served; then completion exactly at expiry
    add_job(1, 4'b0110, rnd_op(), rnd_op(), 0);
    add_job(1, 4'b0111, rnd_op(), rnd_op(), 2);
    drain(200);
    add_job(3, 4'b0101, rnd_op(), rnd_op(), TMO);
    drain(200);

    // fairness: all requesters hold valid continuously
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NREQ; i++)
        add_job(i, 4'(5 + $urandom_range(0, 2)), rnd_op(), rnd_op(), $urandom_range(1, 3));
    drain(500);

    // random traffic
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 5) == 0)
        add_job($urandom_range(0, NREQ-1),
                ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'(5 + $urandom_range(0, 2)),
                rnd_op(), rnd_op(),
                ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO));
      step();
    end
    drain(5000);

    // spurious completion while idle
    spur_rdy = 1'b1;
    step();
    spur_rdy = 1'b0;
    step();
    chk("spurious_busy", busy, 0);
    chk("spurious_rsp", rsp_valid, 0);

    // reset while waiting on the FPU
    add_job(1, 4'b0101, rnd_op(), rnd_op(), 0);
    n = 0;
    step();
    while (!(rspq.size() > 0 && cyc >= last_sample + 3) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) flag("reset_test_setup");
    chk("wait_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_mid_wait");
    rspq.delete(); ackq.delete(); opq.delete(); jobq.delete();
    ack_who = -1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    add_job(3, 4'b0110, rnd_op(), rnd_op(), 2);
    add_job(0, 4'b0101, rnd_op(), rnd_op(), 1);
    rst_n = 1'b1;
    m_last = NREQ - 1;
    next_sample = cyc;
    drive_step();
    drain(200);

    if (rspq.size() != 0 || ackq.size() != 0 || opq.size() != 0) flag("leftover_expectations");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
